// File: rtl/dff_resp_checker.sv
// Checks a DUT's sync-reset and no-reset flops against a cycle-accurate expected model
// over a start/stop or timeout-bounded window, counting mismatches and capturing the first one.
module dff_resp_checker #(
  parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_clk_enable,
  input  logic        i_dut_reset,
  input  logic        i_value,
  input  logic        i_obs_sync_reset,
  input  logic        i_obs_no_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_first_err_cycle,
  output logic [1:0]  o_first_err_mask,
  output logic [15:0] o_cycle_count
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic        exp_sr, exp_nr, v_sr, v_nr;
  logic [7:0]  err_count;
  logic [15:0] cycle_count, first_err_cycle;
  logic [1:0]  first_err_mask, mask;
  logic        start_win, last_cyc;

  assign last_cyc = (cycle_count == MAX_CYCLES - 16'd1);
  assign mask     = (state == CHECK) ?
                    {v_nr & (exp_nr != i_obs_no_reset), v_sr & (exp_sr != i_obs_sync_reset)} : 2'b00;

  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    case (state)
      IDLE, DONE: if (i_start) begin
        state_nxt = CHECK;
        start_win = 1'b1;
      end
      CHECK: if (i_stop || last_cyc) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state           <= IDLE;
      exp_sr          <= 1'b0;
      exp_nr          <= 1'b0;
      v_sr            <= 1'b0;
      v_nr            <= 1'b0;
      err_count       <= '0;
      cycle_count     <= '0;
      first_err_cycle <= '0;
      first_err_mask  <= '0;
    end else begin
      state <= state_nxt;
      if (start_win) begin
        exp_sr          <= 1'b0;
        exp_nr          <= 1'b0;
        v_sr            <= 1'b0;
        v_nr            <= 1'b0;
        err_count       <= '0;
        cycle_count     <= '0;
        first_err_cycle <= '0;
        first_err_mask  <= '0;
      end else if (state == CHECK) begin
        // A gated DUT clock applies neither data nor its sync reset
        if (i_clk_enable) begin
          exp_sr <= i_dut_reset ? 1'b0 : i_value;
          exp_nr <= i_value;
          v_sr   <= 1'b1;
          v_nr   <= 1'b1;
        end
        if (|mask) begin
          if (err_count == 8'd0) begin
            first_err_cycle <= cycle_count;
            first_err_mask  <= mask;
          end
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        // Count holds on the exit edge so DONE reports the final compared cycle
        if (state_nxt == CHECK && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
      end
    end
  end

  assign o_busy            = !sync_reset && (state == CHECK);
  assign o_done            = !sync_reset && (state == DONE);
  assign o_pass            = o_done && (err_count == 8'd0);
  assign o_err_count       = sync_reset ? 8'd0  : err_count;
  assign o_first_err_cycle = sync_reset ? 16'd0 : first_err_cycle;
  assign o_first_err_mask  = sync_reset ? 2'd0  : first_err_mask;
  assign o_cycle_count     = sync_reset ? 16'd0 : cycle_count;

endmodule
